// File: rtl/turn_signal_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module      : turn_signal_sequencer                                      |
// | Description : Three-lamp tail-light sequencer for left/right/hazard      |
// |               requests. The FSM steps on a divided tick. Lamp outputs    |
// |               are registered and active-low.                             |
// |               Optional brake input is enabled by `define TURN_BRAKE_EN.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module turn_signal_sequencer #(
   parameter int TICK_DIV = 12_500_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       left,
   input  logic       right,
   input  logic       hazard,
`ifdef TURN_BRAKE_EN
   input  logic       brake,
`endif
   output logic [2:0] left_lamps,
   output logic [2:0] right_lamps,
   output logic       busy
);

   localparam int              c_CW       = $clog2(TICK_DIV);
   localparam logic [c_CW-1:0] c_TICK_MAX = c_CW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2,
      ST_HAZ   = 2'd3
   } state_t;

   logic [c_CW-1:0] r_count;
   logic            r_left_q;
   logic            r_right_q;
   logic            r_hazard_q;
   state_t          r_state;
   logic [1:0]      r_step;

   logic            w_tick;
   state_t          w_req;
   logic [1:0]      w_step;
   logic [2:0]      w_side_off;

   function automatic logic [2:0] turn_pattern(input logic [1:0] s);
      case (s)
         2'd0:    turn_pattern = 3'b111;
         2'd1:    turn_pattern = 3'b110;
         2'd2:    turn_pattern = 3'b100;
         default: turn_pattern = 3'b000;
      endcase
   endfunction

`ifdef TURN_BRAKE_EN
   logic r_brake_q;

   always_ff @(posedge clk) begin
      if (reset) r_brake_q <= 1'b0;
      else       r_brake_q <= brake;
   end

   assign w_side_off = r_brake_q ? 3'b000 : 3'b111;
`else
   assign w_side_off = 3'b111;
`endif

   assign w_tick = (r_count == c_TICK_MAX);

   // A new mode always starts at step 1. In HAZ, odd steps are the ON phase.
   always_comb begin
      w_req = ST_IDLE;
      if (r_hazard_q)                   w_req = ST_HAZ;
      else if (r_left_q && !r_right_q)  w_req = ST_LEFT;
      else if (r_right_q && !r_left_q)  w_req = ST_RIGHT;
      w_step = (r_state == w_req) ? r_step + 2'd1 : 2'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count     <= '0;
         r_left_q    <= 1'b0;
         r_right_q   <= 1'b0;
         r_hazard_q  <= 1'b0;
         r_state     <= ST_IDLE;
         r_step      <= 2'd0;
         left_lamps  <= 3'b111;
         right_lamps <= 3'b111;
         busy        <= 1'b0;
      end else begin
         r_count    <= w_tick ? '0 : r_count + c_CW'(1);
         r_left_q   <= left;
         r_right_q  <= right;
         r_hazard_q <= hazard;
         if (w_tick) begin
            r_state <= w_req;
            busy    <= (w_req != ST_IDLE);
            case (w_req)
               ST_LEFT: begin
                  r_step      <= w_step;
                  left_lamps  <= turn_pattern(w_step);
                  right_lamps <= w_side_off;
               end
               ST_RIGHT: begin
                  r_step      <= w_step;
                  left_lamps  <= w_side_off;
                  right_lamps <= turn_pattern(w_step);
               end
               ST_HAZ: begin
                  r_step      <= w_step;
                  left_lamps  <= w_step[0] ? 3'b000 : 3'b111;
                  right_lamps <= w_step[0] ? 3'b000 : 3'b111;
               end
               default: begin
                  r_step      <= 2'd0;
                  left_lamps  <= w_side_off;
                  right_lamps <= w_side_off;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_turn_signal_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_turn_signal_sequencer                                   |
// | Description : Directed bench for turn_signal_sequencer, TICK_DIV = 4.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_turn_signal_sequencer;

   localparam int c_TICK_DIV = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       left = 1'b0;
   logic       right = 1'b0;
   logic       hazard = 1'b0;
`ifdef TURN_BRAKE_EN
   logic       brake = 1'b0;
`endif
   logic [2:0] left_lamps;
   logic [2:0] right_lamps;
   logic       busy;

   turn_signal_sequencer #(.TICK_DIV(c_TICK_DIV)) dut (
      .clk        (clk),
      .reset      (reset),
      .left       (left),
      .right      (right),
      .hazard     (hazard),
`ifdef TURN_BRAKE_EN
      .brake      (brake),
`endif
      .left_lamps (left_lamps),
      .right_lamps(right_lamps),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] l;
      logic [2:0] r;
      logic       b;
   } exp_t;

   exp_t sb[$];
   exp_t held;
   int   errors = 0;
   int   checks = 0;
   int   phase  = 0;

   // Reference prescaler: the edge after phase reaches TICK_DIV-1 is a tick.
   always @(posedge clk) begin
      if (reset) phase <= 0;
      else       phase <= (phase == c_TICK_DIV - 1) ? 0 : phase + 1;
   end

   task automatic check(input string tag, input exp_t obs, input exp_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed l=%b r=%b busy=%b, expected l=%b r=%b busy=%b",
                tag, obs.l, obs.r, obs.b, exp.l, exp.r, exp.b);
      end
   endtask

   function automatic exp_t observed();
      observed = '{l: left_lamps, r: right_lamps, b: busy};
   endfunction

   task automatic wait_tick(input string tag);
      int n = 0;
      while (phase != c_TICK_DIV - 1 && n < 2 * c_TICK_DIV) begin
         @(posedge clk); #1;
         n++;
         check({tag, "_hold"}, observed(), held);
      end
      if (n >= 2 * c_TICK_DIV) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: no tick within %0d cycles", tag, n);
      end
      @(posedge clk); #1;
   endtask

   task automatic expect_tick(input string tag, input logic [2:0] l,
                              input logic [2:0] r, input logic b);
      exp_t e;
      sb.push_back('{l: l, r: r, b: b});
      wait_tick(tag);
      e = sb.pop_front();
      check(tag, observed(), e);
      held = e;
   endtask

   task automatic hold_reset(input string tag);
      reset = 1'b1;
      held  = '{l: 3'b111, r: 3'b111, b: 1'b0};
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check(tag, observed(), held);
      end
      reset = 1'b0;
   endtask

   initial begin
      #1;
      hold_reset("reset_init");

      left = 1'b1;
      expect_tick("left_s1", 3'b110, 3'b111, 1'b1);
      expect_tick("left_s2", 3'b100, 3'b111, 1'b1);
      expect_tick("left_s3", 3'b000, 3'b111, 1'b1);
      expect_tick("left_s0", 3'b111, 3'b111, 1'b1);
      expect_tick("left_wrap", 3'b110, 3'b111, 1'b1);

      hold_reset("reset_mid");
      left = 1'b0;
      expect_tick("post_reset", 3'b111, 3'b111, 1'b0);

      right = 1'b1;
      expect_tick("right_s1", 3'b111, 3'b110, 1'b1);
      expect_tick("right_s2", 3'b111, 3'b100, 1'b1);
      hazard = 1'b1;
      expect_tick("haz_on1", 3'b000, 3'b000, 1'b1);
      expect_tick("haz_off", 3'b111, 3'b111, 1'b1);
      expect_tick("haz_on2", 3'b000, 3'b000, 1'b1);
      hazard = 1'b0;
      right  = 1'b0;
      expect_tick("haz_release", 3'b111, 3'b111, 1'b0);

      left  = 1'b1;
      right = 1'b1;
      for (int i = 0; i < 5; i++)
         expect_tick("both_idle", 3'b111, 3'b111, 1'b0);
      right = 1'b0;

      expect_tick("sw_left_s1", 3'b110, 3'b111, 1'b1);
      expect_tick("sw_left_s2", 3'b100, 3'b111, 1'b1);
      left  = 1'b0;
      right = 1'b1;
      expect_tick("sw_right_s1", 3'b111, 3'b110, 1'b1);
      expect_tick("sw_right_s2", 3'b111, 3'b100, 1'b1);
      right = 1'b0;
      expect_tick("sw_release", 3'b111, 3'b111, 1'b0);

      hazard = 1'b1;
      left   = 1'b1;
      expect_tick("haz_priority", 3'b000, 3'b000, 1'b1);
      hazard = 1'b0;
      left   = 1'b0;
      expect_tick("haz_prio_rel", 3'b111, 3'b111, 1'b0);

`ifdef TURN_BRAKE_EN
      brake = 1'b1;
      left  = 1'b1;
      expect_tick("brk_left_s1", 3'b110, 3'b000, 1'b1);
      expect_tick("brk_left_s2", 3'b100, 3'b000, 1'b1);
      expect_tick("brk_left_s3", 3'b000, 3'b000, 1'b1);
      expect_tick("brk_left_s0", 3'b111, 3'b000, 1'b1);
      left = 1'b0;
      expect_tick("brk_idle", 3'b000, 3'b000, 1'b0);
      hazard = 1'b1;
      expect_tick("brk_haz_on", 3'b000, 3'b000, 1'b1);
      expect_tick("brk_haz_off", 3'b111, 3'b111, 1'b1);
      hazard = 1'b0;
      brake  = 1'b0;
      expect_tick("brk_release", 3'b111, 3'b111, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
